// File: rtl/csoc_scan_ctrl_pkg.sv
// Shared op codes, FSM state encodings and CRC helper for the CSoC scan controller.
// The CRC helper exists only when CSOC_SCAN_CRC_EN is defined.
package csoc_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    OpShift   = 2'd0,
    OpCapture = 2'd1,
    OpRun     = 2'd2,
    OpCrst    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWait = 3'd1,
    StLo   = 3'd2,
    StHi   = 3'd3,
    StFin  = 3'd4
  } state_e;

`ifdef CSOC_SCAN_CRC_EN
  // CRC-8, poly 0x07, MSB first, one byte per call.
  function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

endpackage

// File: rtl/csoc_scan_ctrl_if.sv
// Host-side bus of the scan controller: command, scan-in and scan-out handshakes.
// The master side is the command parser/host, the slave side is csoc_scan_ctrl.
interface csoc_scan_ctrl_if #(
  parameter int unsigned LEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             done;
  logic             si_valid;
  logic             si_ready;
  logic [7:0]       si_data;
  logic             so_valid;
  logic             so_ready;
  logic [7:0]       so_data;
  logic [7:0]       sig;

  modport master (
    output cmd_valid, cmd_op, cmd_len, si_valid, si_data, so_ready,
    input  cmd_ready, done, si_ready, so_valid, so_data, sig
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, si_valid, si_data, so_ready,
    output cmd_ready, done, si_ready, so_valid, so_data, sig
  );
endinterface

// File: rtl/csoc_scan_ctrl_clk_gen.sv
// csoc_clk phase generator: one start launches a LO phase then a HI phase of CLK_DIV cycles each.
// lo_last/hi_last flag the final cycle of each phase.
module csoc_scan_ctrl_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stall,
  output logic csoc_clk,
  output logic lo_last,
  output logic hi_last
);
  localparam int unsigned PhW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PhW-1:0] PhMax = PhW'(CLK_DIV - 1);

  logic [PhW-1:0] ph_q;
  logic           run_q;
  logic           hi_q;
  logic           ph_end;

  assign ph_end   = run_q && !stall && (ph_q == PhMax);
  assign lo_last  = ph_end && !hi_q;
  assign hi_last  = ph_end && hi_q;
  assign csoc_clk = hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q  <= '0;
      run_q <= 1'b0;
      hi_q  <= 1'b0;
    end else if (start) begin
      ph_q  <= '0;
      run_q <= 1'b1;
      hi_q  <= 1'b0;
    end else if (run_q && !stall) begin
      if (ph_end) begin
        ph_q <= '0;
        if (hi_q) begin
          run_q <= 1'b0;
          hi_q  <= 1'b0;
        end else begin
          hi_q <= 1'b1;
        end
      end else begin
        ph_q <= ph_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/csoc_scan_ctrl.sv
// CSoC scan sequencer: SHIFT/CAPTURE/RUN/CRST ops driving csoc_clk, test_se/tm and csoc_rstn.
// Define CSOC_SCAN_CRC_EN to accumulate a CRC-8 signature over scan-out bytes on sig.
module csoc_scan_ctrl
  import csoc_scan_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned LEN_W   = 16
) (
  input  logic            clk,
  input  logic            rst,
  csoc_scan_ctrl_if.slave bus,
  output logic            csoc_clk,
  output logic            csoc_rstn,
  output logic            csoc_test_se,
  output logic            csoc_test_tm,
  output logic [7:0]      csoc_data_o,
  input  logic [7:0]      csoc_data_i
);
  state_e           state_q;
  op_e              op_q;
  op_e              cmd_op;
  logic [LEN_W-1:0] cnt_q;
  logic             cmd_ready_q, done_q, si_ready_q, so_valid_q;
  logic [7:0]       so_data_q, data_o_q;
  logic             rstn_q, se_q, tm_q;
  logic             accept, si_hs, last_pulse, gen_start, sample, lo_last, hi_last;

  assign cmd_op     = op_e'(bus.cmd_op);
  assign accept     = cmd_ready_q && bus.cmd_valid;
  assign si_hs      = (state_q == StWait) && si_ready_q && bus.si_valid;
  assign last_pulse = (cnt_q == LEN_W'(1));
  assign sample     = lo_last && (op_q == OpShift);
  // SHIFT relaunches pulses from S_WAIT; the other ops chain pulses back to back.
  assign gen_start  = (accept && (bus.cmd_len != '0) && (cmd_op != OpShift)) || si_hs ||
                      (hi_last && !last_pulse && (op_q != OpShift));

  csoc_scan_ctrl_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .start    (gen_start),
    .stall    (1'b0),
    .csoc_clk (csoc_clk),
    .lo_last  (lo_last),
    .hi_last  (hi_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OpShift;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      si_ready_q  <= 1'b0;
      so_valid_q  <= 1'b0;
      so_data_q   <= 8'h00;
      data_o_q    <= 8'h00;
      rstn_q      <= 1'b1;
      se_q        <= 1'b0;
      tm_q        <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      si_ready_q <= (state_q == StWait) && !so_valid_q && !si_hs;

      // A fresh sample takes priority over the host draining the slot.
      if (sample) begin
        so_valid_q <= 1'b1;
        so_data_q  <= csoc_data_i;
      end else if (bus.so_ready) begin
        so_valid_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (accept) begin
            op_q        <= cmd_op;
            cnt_q       <= bus.cmd_len;
            cmd_ready_q <= 1'b0;
            unique case (cmd_op)
              OpShift:   begin tm_q <= 1'b1; se_q <= 1'b1; end
              OpCapture: begin tm_q <= 1'b1; se_q <= 1'b0; end
              OpRun:     begin tm_q <= 1'b0; se_q <= 1'b0; end
              OpCrst:    begin se_q <= 1'b0; rstn_q <= (bus.cmd_len == '0); end
              default:   ;
            endcase
            if (bus.cmd_len == '0) begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end else if (cmd_op == OpShift) begin
              state_q <= StWait;
            end else begin
              state_q <= StLo;
            end
          end
        end
        StWait: begin
          if (si_hs) begin
            data_o_q <= bus.si_data;
            state_q  <= StLo;
          end
        end
        StLo: begin
          if (lo_last) state_q <= StHi;
        end
        StHi: begin
          if (hi_last) begin
            cnt_q <= cnt_q - LEN_W'(1);
            if (last_pulse) begin
              state_q <= StFin;
              done_q  <= 1'b1;
              rstn_q  <= 1'b1;
            end else if (op_q == OpShift) begin
              state_q <= StWait;
            end else begin
              state_q <= StLo;
            end
          end
        end
        StFin: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef CSOC_SCAN_CRC_EN
  logic [7:0] sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 8'h00;
    end else if (accept && (cmd_op == OpShift)) begin
      sig_q <= 8'h00;
    end else if (sample) begin
      sig_q <= crc8_upd(sig_q, csoc_data_i);
    end
  end

  assign bus.sig = sig_q;
`else
  assign bus.sig = 8'h00;
`endif

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.done      = done_q;
  assign bus.si_ready  = si_ready_q;
  assign bus.so_valid  = so_valid_q;
  assign bus.so_data   = so_data_q;
  assign csoc_rstn     = rstn_q;
  assign csoc_test_se  = se_q;
  assign csoc_test_tm  = tm_q;
  assign csoc_data_o   = data_o_q;
endmodule
